secuenciador_alu: RTL and testbench

- Issuing end of the 8-bit instruction / 4-bit operand interface of the team's 4-bit ALU operator.
- Holds a small program memory and a 4-entry × 4-bit register file.
- Fetches each instruction, drives instr/A/B to the operator, waits a fixed latency, and writes the returned 4-bit result back.
- Sits between the board-level loader (switches/UART) and the operator.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/secuenciador_alu_banco_reg.sv | 36 +++
 rtl/secuenciador_alu.sv | 160 ++++++++++++++++
 tb/tb_secuenciador_alu.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction field positions and sequencer states
// Purpose : common definitions for the ALU operator interface and its sequencer.
// Contents: OP_* opcode constants, instruction field bit positions, state_t enum.
// Optional: SECUENCIADOR_STEP_EN adds the S_PAUSE state.
package alu_pkg;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_COMP = 3'd1;
    localparam logic [2:0] OP_SL   = 3'd2;
    localparam logic [2:0] OP_SR   = 3'd3;
    localparam logic [2:0] OP_CMI  = 3'd4;
    localparam logic [2:0] OP_CMM  = 3'd5;
    localparam logic [2:0] OP_SA   = 3'd6;
    localparam logic [2:0] OP_LO   = 3'd7;

    // Instruction word: [7:5] opcode, [4:3] ra, [2:1] rb, [0] halt
    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int RA_MSB   = 4;
    localparam int RA_LSB   = 3;
    localparam int RB_MSB   = 2;
    localparam int RB_LSB   = 1;
    localparam int HALT_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
`ifdef SECUENCIADOR_STEP_EN
        ,S_PAUSE
`endif
    } state_t;

endpackage

// File: rtl/secuenciador_alu_banco_reg.sv
// rtl/secuenciador_alu_banco_reg.sv - 4 x 4-bit register file
// Purpose: operand storage for the sequencer; one write port, two operand
//          read ports and one debug read port, all reads combinational.
// Ports  : i_clk, i_rst (async, active-high), i_we/i_waddr/i_wdata write port,
//          i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b, i_dbg_sel/o_dbg_dato.
module banco_reg (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [1:0] i_waddr,
    input  logic [3:0] i_wdata,
    input  logic [1:0] i_raddr_a,
    input  logic [1:0] i_raddr_b,
    input  logic [1:0] i_dbg_sel,
    output logic [3:0] o_rdata_a,
    output logic [3:0] o_rdata_b,
    output logic [3:0] o_dbg_dato
);

    logic [3:0] r_regs [4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_dato = r_regs[i_dbg_sel];

endmodule

// File: rtl/secuenciador_alu.sv
// rtl/secuenciador_alu.sv - instruction sequencer driving the 4-bit ALU operator
// Purpose: holds program memory and register file, fetches each instruction,
//          presents instr/A/B to the operator, waits LAT cycles, writes back.
// Ports  : clk, rst (async, active-high); loader ld_we/ld_tgt/ld_addr/ld_data;
//          start; operator side instr/A/B out, dato_mux in; status busy/done;
//          debug dbg_sel/dbg_dato.
// Optional: SECUENCIADOR_STEP_EN adds input step and a PAUSE state that gates
//          every FETCH on a step pulse.
module secuenciador_alu
    import alu_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int LAT        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef SECUENCIADOR_STEP_EN
    input  logic                          step,
`endif
    input  logic                          ld_we,
    input  logic                          ld_tgt,
    input  logic [$clog2(PROG_DEPTH)-1:0] ld_addr,
    input  logic [7:0]                    ld_data,
    input  logic                          start,
    output logic [7:0]                    instr,
    output logic [3:0]                    A,
    output logic [3:0]                    B,
    input  logic [3:0]                    dato_mux,
    output logic                          busy,
    output logic                          done,
    input  logic [1:0]                    dbg_sel,
    output logic [3:0]                    dbg_dato
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_DEPTH - 1);

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [7:0]      r_ir;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_prog [PROG_DEPTH];

    logic            w_ld_ok;
    logic            w_reg_we;
    logic [1:0]      w_reg_waddr;
    logic [3:0]      w_reg_wdata;
    logic [3:0]      w_rd_a;
    logic [3:0]      w_rd_b;
    logic [1:0]      w_ra;
    logic [1:0]      w_rb;

    // Loader writes are honoured only while idle.
    assign w_ld_ok = (r_state == S_IDLE) && ld_we;
    assign w_ra    = r_ir[RA_MSB:RA_LSB];
    assign w_rb    = r_ir[RB_MSB:RB_LSB];

    // Single register write port shared by writeback and loader; the two
    // sources can never be active together because they need different states.
    assign w_reg_we    = (r_state == S_WB) || (w_ld_ok && ld_tgt);
    assign w_reg_waddr = (r_state == S_WB) ? w_ra     : ld_addr[1:0];
    assign w_reg_wdata = (r_state == S_WB) ? dato_mux : ld_data[3:0];

    banco_reg u_banco_reg (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_we       (w_reg_we),
        .i_waddr    (w_reg_waddr),
        .i_wdata    (w_reg_wdata),
        .i_raddr_a  (w_ra),
        .i_raddr_b  (w_rb),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_dbg_dato (dbg_dato)
    );

    // Program memory deliberately has no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (w_ld_ok && !ld_tgt) begin
            r_prog[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            instr   <= '0;
            A       <= '0;
            B       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        busy    <= 1'b1;
`ifdef SECUENCIADOR_STEP_EN
                        r_state <= S_PAUSE;
`else
                        r_state <= S_FETCH;
`endif
                    end
                end
`ifdef SECUENCIADOR_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                S_FETCH: begin
                    r_ir    <= r_prog[r_pc];
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    instr   <= r_ir;
                    A       <= w_rd_a;
                    B       <= w_rd_b;
                    r_cnt   <= CW'(LAT);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter is loaded with LAT, so WAIT lasts exactly LAT cycles.
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (r_ir[HALT_BIT] || (r_pc == LAST_ADDR)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + AW'(1);
`ifdef SECUENCIADOR_STEP_EN
                        r_state <= S_PAUSE;
`else
                        r_state <= S_FETCH;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_alu.sv
// tb/tb_secuenciador_alu.sv - directed self-checking bench for secuenciador_alu
module tb_secuenciador_alu;

    localparam int PROG_DEPTH = 16;
    localparam int LAT        = 3;
    localparam int AW         = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_we;
    logic          ld_tgt;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          start;
    logic [7:0]    instr;
    logic [3:0]    A;
    logic [3:0]    B;
    logic [3:0]    dato_mux;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_sel;
    logic [3:0]    dbg_dato;
`ifdef SECUENCIADOR_STEP_EN
    logic          step;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    secuenciador_alu #(.PROG_DEPTH(PROG_DEPTH), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SECUENCIADOR_STEP_EN
        .step     (step),
`endif
        .ld_we    (ld_we),
        .ld_tgt   (ld_tgt),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .instr    (instr),
        .A        (A),
        .B        (B),
        .dato_mux (dato_mux),
        .busy     (busy),
        .done     (done),
        .dbg_sel  (dbg_sel),
        .dbg_dato (dbg_dato)
    );

    // Operator model: result is only valid once instr/A/B have been stable LAT cycles.
    logic [3:0]  op_res;
    logic [15:0] last_iab = 16'h0;
    int          stable_cnt = 0;

    always_comb begin
        case (instr[7:5])
            3'd0:    op_res = A + B;
            3'd4:    op_res = (A > B) ? 4'd1 : 4'd0;
            default: op_res = A ^ B;
        endcase
    end

    always @(negedge clk) begin
        if ({instr, A, B} != last_iab) begin
            last_iab   = {instr, A, B};
            stable_cnt = 0;
        end else if (stable_cnt < 1000) begin
            stable_cnt = stable_cnt + 1;
        end
    end

    assign dato_mux = (stable_cnt >= LAT) ? op_res : 4'hE;

    task automatic load(input logic tgt, input logic [AW-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_we = 1'b1; ld_tgt = tgt; ld_addr = addr; ld_data = data;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic get_reg(input logic [1:0] sel, output logic [3:0] v);
        dbg_sel = sel;
        #1 v = dbg_dato;
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1 n++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        logic [3:0] v;
        rst = 1'b1; ld_we = 1'b0; ld_tgt = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; dbg_sel = 2'd0;
`ifdef SECUENCIADOR_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({instr, A, B, busy, done} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {instr, A, B, busy, done});
        end
        for (int i = 0; i < 4; i++) begin
            get_reg(2'(i), v);
            checks++;
            if (v !== 4'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=0", i, v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        logic [3:0] v;
        load(1'b1, 4'd0, 8'h03);
        load(1'b1, 4'd1, 8'h05);
        load(1'b0, 4'd0, 8'h03);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_start got=%b exp=1", busy);
        end
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1 n++;
            if (n >= 2 && n <= 5) begin
                checks++;
                if ({instr, A, B} !== 16'h0335) begin
                    failures++;
                    $display("FAIL single_iab cyc=%0d got=%h exp=0335", n, {instr, A, B});
                end
            end
            if (done) break;
        end
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL single_done_cycle got=%0d exp=6", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_end got=%b exp=0", busy);
        end
        get_reg(2'd0, v);
        checks++;
        if (v !== 4'd8) begin
            failures++;
            $display("FAIL single_r0 got=%0d exp=8", v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic load_prog3();
        load(1'b1, 4'd0, 8'h09);
        load(1'b1, 4'd1, 8'h09);
        load(1'b0, 4'd0, 8'h02);
        load(1'b0, 4'd1, 8'h82);
        load(1'b0, 4'd2, 8'h83);
    endtask

    task automatic test_multi();
        int n;
        logic [3:0] v;
        load_prog3();
        dbg_sel = 2'd0;
        pulse_start();
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (n == 7) begin
                checks++;
                if (dbg_dato !== 4'd2) begin
                    failures++;
                    $display("FAIL multi_r0_wb1 got=%0d exp=2", dbg_dato);
                end
            end
            if (n == 8) begin
                checks++;
                if ({instr, A, B} !== 16'h8229) begin
                    failures++;
                    $display("FAIL multi_iab2 got=%h exp=8229", {instr, A, B});
                end
            end
            if (n == 14) begin
                checks++;
                if ({instr, A, B} !== 16'h8309) begin
                    failures++;
                    $display("FAIL multi_iab3 got=%h exp=8309", {instr, A, B});
                end
            end
            if (done) break;
        end
        checks++;
        if (n !== 18) begin
            failures++;
            $display("FAIL multi_done_cycle got=%0d exp=18", n);
        end
        get_reg(2'd0, v);
        checks++;
        if (v !== 4'd0) begin
            failures++;
            $display("FAIL multi_r0 got=%0d exp=0", v);
        end
    endtask

    task automatic test_no_halt();
        int n;
        int extra;
        logic [3:0] v0, v1, v2;
        load(1'b1, 4'd0, 8'h00);
        load(1'b1, 4'd1, 8'h01);
        load(1'b1, 4'd2, 8'h00);
        for (int i = 0; i < 15; i++) load(1'b0, AW'(i), 8'h02);
        load(1'b0, 4'd15, 8'h12);
        pulse_start();
        run_until_done(n);
        checks++;
        if (n !== 96) begin
            failures++;
            $display("FAIL nohalt_done_cycle got=%0d exp=96", n);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done) extra++;
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL nohalt_single_done extra=%0d busy=%b exp=0/0", extra, busy);
        end
        get_reg(2'd0, v0);
        get_reg(2'd1, v1);
        get_reg(2'd2, v2);
        checks++;
        if ({v0, v1, v2} !== 12'hF11) begin
            failures++;
            $display("FAIL nohalt_regs got=%h exp=f11", {v0, v1, v2});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [3:0] v;
        load_prog3();
        pulse_start();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({instr, A, B, busy, done} !== 18'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0", {instr, A, B, busy, done});
        end
        get_reg(2'd0, v);
        checks++;
        if (v !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_r0 got=%0d exp=0", v);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b exp=0", busy);
        end
        load(1'b1, 4'd0, 8'h09);
        load(1'b1, 4'd1, 8'h09);
        pulse_start();
        run_until_done(n);
        get_reg(2'd0, v);
        checks++;
        if (n !== 18 || v !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_rerun cyc=%0d r0=%0d exp=18/0", n, v);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [3:0] v;
        load(1'b1, 4'd0, 8'h09);
        dbg_sel = 2'd1;
        pulse_start();
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (n == 3) begin
                start = 1'b1; ld_we = 1'b1; ld_tgt = 1'b1; ld_addr = 4'd1; ld_data = 8'h07;
            end
            if (n == 4) begin
                ld_tgt = 1'b0; ld_addr = 4'd2; ld_data = 8'h00;
            end
            if (n == 5) begin
                start = 1'b0; ld_we = 1'b0;
                checks++;
                if (dbg_dato !== 4'd9) begin
                    failures++;
                    $display("FAIL busy_reg_write got=%0d exp=9", dbg_dato);
                end
            end
            if (done) break;
        end
        checks++;
        if (n !== 18) begin
            failures++;
            $display("FAIL busy_no_restart got=%0d exp=18", n);
        end
        load(1'b1, 4'd0, 8'h09);
        pulse_start();
        run_until_done(n);
        get_reg(2'd1, v);
        checks++;
        if (n !== 18 || v !== 4'd9) begin
            failures++;
            $display("FAIL busy_prog_intact cyc=%0d r1=%0d exp=18/9", n, v);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [3:0] v0, v3;
        load(1'b0, 4'd0, 8'h02);
        load(1'b1, 4'd0, 8'h01);
        load(1'b1, 4'd1, 8'h02);
        load(1'b1, 4'd3, 8'h00);
        @(negedge clk);
        ld_we = 1'b1; ld_tgt = 1'b0; ld_addr = 4'd0; ld_data = 8'h03; start = 1'b1;
        @(posedge clk);
        #1 ld_we = 1'b0; start = 1'b0;
        run_until_done(n);
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL b2b_done_cycle got=%0d exp=6", n);
        end
        ld_we = 1'b1; ld_tgt = 1'b1; ld_addr = 4'd3; ld_data = 8'h0A;
        @(posedge clk);
        #1 ld_we = 1'b0;
        get_reg(2'd0, v0);
        get_reg(2'd3, v3);
        checks++;
        if ({v0, v3} !== 8'h30) begin
            failures++;
            $display("FAIL b2b_regs got=%h exp=30", {v0, v3});
        end
    endtask

`ifdef SECUENCIADOR_STEP_EN
    task automatic test_step();
        int n;
        int dcnt;
        logic [7:0] saved;
        logic [3:0] v;
        load(1'b0, 4'd0, 8'h02);
        load(1'b0, 4'd1, 8'h03);
        load(1'b1, 4'd0, 8'h01);
        load(1'b1, 4'd1, 8'h02);
        saved = instr;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || instr !== saved) begin
            failures++;
            $display("FAIL step_paused busy=%b instr=%h exp=1/%h", busy, instr, saved);
        end
        @(negedge clk); step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done) dcnt++;
        end
        get_reg(2'd0, v);
        checks++;
        if (v !== 4'd3 || busy !== 1'b1 || dcnt !== 0 || instr !== 8'h02) begin
            failures++;
            $display("FAIL step_one r0=%0d busy=%b done=%0d instr=%h exp=3/1/0/02", v, busy, dcnt, instr);
        end
        @(negedge clk); step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        run_until_done(n);
        get_reg(2'd0, v);
        checks++;
        if (n > 20 || v !== 4'd5) begin
            failures++;
            $display("FAIL step_two cyc=%0d r0=%0d exp<=20/5", n, v);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef SECUENCIADOR_STEP_EN
        test_step();
`else
        test_single();
        test_multi();
        test_no_halt();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
